// File: rtl/chip8_pkg.sv
// Shared constants and types for the CHIP-8 serial keypad receiver:
// command encodings, receiver state enum and the ASCII hex-digit helper.
package chip8_pkg;

  localparam logic [3:0] KP_CMD_PRESS   = 4'h1;
  localparam logic [3:0] KP_CMD_RELEASE = 4'h2;
  localparam logic [7:0] KP_CMD_CLEAR   = 8'h30;
  localparam logic [7:0] KP_ASCII_SPACE = 8'h20;

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_e;

  // Returns {hit, digit}; letters have low nibble 1..6, so digit = nibble + 9.
  function automatic logic [4:0] kp_ascii_hex(input logic [7:0] b);
    logic [4:0] r;
    r = '0;
    if (b >= 8'h30 && b <= 8'h39) begin
      r = {1'b1, b[3:0]};
    end else if ((b >= 8'h41 && b <= 8'h46) || (b >= 8'h61 && b <= 8'h66)) begin
      r = {1'b1, b[3:0] + 4'd9};
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF synchronizer, mid-bit sampling FSM, byte output
// with one-cycle rx_valid / frame_err pulses.
module uart_rx
  import chip8_pkg::*;
#(
  parameter int CLK_FREQ = 27_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err
);

  localparam int CPB   = CLK_FREQ / BAUD;
  localparam int CNT_W = $clog2(CPB);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(CPB / 2);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CPB - 1);

  logic             sync1_q, sync2_q;
  logic             rxs;
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       rx_byte_q, rx_byte_d;
  logic             rx_valid_q, rx_valid_d;
  logic             frame_err_q, frame_err_d;

  assign rxs = sync2_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    bit_d       = bit_q;
    shift_d     = shift_q;
    rx_byte_d   = rx_byte_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      WAIT_IDLE: begin
        cnt_d = '0;
        if (rxs) state_d = IDLE;
      end
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (!rxs) state_d = START;
      end
      START: begin
        if (cnt_q == HALF) begin
          cnt_d   = '0;
          state_d = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          shift_d = {rxs, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == LAST) begin
          cnt_d = '0;
          if (rxs) begin
            rx_byte_d  = shift_q;
            rx_valid_d = 1'b1;
            state_d    = IDLE;
          end else begin
            // Line held low past the stop bit: wait for a real idle level.
            frame_err_d = 1'b1;
            state_d     = WAIT_IDLE;
          end
        end
      end
      default: state_d = WAIT_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    sync1_q <= rx;
    sync2_q <= sync1_q;
    shift_q <= shift_d;
    if (rst) begin
      state_q     <= WAIT_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      rx_byte_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      rx_byte_q   <= rx_byte_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign rx_byte   = rx_byte_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;

endmodule

// File: rtl/uart_keypad_rx.sv
// Serial hex keypad: UART bytes decoded into press/release commands for a
// 16-key state vector. Define KEYPAD_ASCII_EN to add ASCII hex-digit decode.
module uart_keypad_rx
  import chip8_pkg::*;
#(
  parameter int CLK_FREQ = 27_000_000,
  parameter int BAUD     = 115200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rx,
  output logic [15:0] keys,
  output logic        key_event,
  output logic [3:0]  key_idx,
  output logic [7:0]  rx_byte,
  output logic        rx_valid,
  output logic        frame_err
);

  logic [15:0] keys_q, keys_d;
  logic [3:0]  key_idx_q, key_idx_d;
  logic        key_event_q, key_event_d;
  logic        ascii_hit;

  uart_rx #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD)
  ) u_uart_rx (
    .clk      (clk),
    .rst      (rst),
    .rx       (uart_rx),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .frame_err(frame_err)
  );

`ifdef KEYPAD_ASCII_EN
  logic [4:0] ascii_dec;
  assign ascii_dec = kp_ascii_hex(rx_byte);
`endif

  always_comb begin
    keys_d      = keys_q;
    key_idx_d   = key_idx_q;
    key_event_d = 1'b0;
    ascii_hit   = 1'b0;
    if (rx_valid) begin
`ifdef KEYPAD_ASCII_EN
      // ASCII takes priority, so '0' (0x30) is digit 0 rather than release-all.
      if (ascii_dec[4]) begin
        ascii_hit   = 1'b1;
        keys_d      = 16'h0001 << ascii_dec[3:0];
        key_idx_d   = ascii_dec[3:0];
        key_event_d = 1'b1;
      end else if (rx_byte == KP_ASCII_SPACE) begin
        ascii_hit = 1'b1;
        keys_d    = '0;
      end
`endif
      if (!ascii_hit) begin
        if (rx_byte[7:4] == KP_CMD_PRESS) begin
          keys_d[rx_byte[3:0]] = 1'b1;
          key_idx_d            = rx_byte[3:0];
          key_event_d          = 1'b1;
        end else if (rx_byte[7:4] == KP_CMD_RELEASE) begin
          keys_d[rx_byte[3:0]] = 1'b0;
        end else if (rx_byte == KP_CMD_CLEAR) begin
          keys_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      keys_q      <= '0;
      key_idx_q   <= '0;
      key_event_q <= 1'b0;
    end else begin
      keys_q      <= keys_d;
      key_idx_q   <= key_idx_d;
      key_event_q <= key_event_d;
    end
  end

  assign keys      = keys_q;
  assign key_idx   = key_idx_q;
  assign key_event = key_event_q;

endmodule

// File: doc/uart_keypad_rx.md
# uart_keypad_rx

Serial keypad input for the CHIP-8 core, on the receive side of the same 8N1 UART link the display streamer transmits on. The block deserializes bytes arriving on `uart_rx` and decodes them into press and release commands for the 16-key hex keypad. It presents a 16-bit key-state vector to the CPU, plus a one-cycle press event that the `FX0A` wait-for-key instruction uses.

## Interface
- `CLK_FREQ`, default 27_000_000: clock frequency in Hz.
- `BAUD`, default 115200: line rate. `CLKS_PER_BIT = CLK_FREQ/BAUD` (integer division), which must be at least 4.
- `clk` input, 1 bit: single clock; all logic is on the rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `uart_rx` input, 1 bit: serial line, asynchronous; idle level is high.
- `keys` output, 16 bits: bit n = 1 means key n is held.
- `key_event` output, 1 bit: one-cycle pulse on every accepted press command.
- `key_idx` output, 4 bits: index of the most recent pressed key; holds its value between events.
- `rx_byte` output, 8 bits: last received byte.
- `rx_valid` output, 1 bit: one-cycle pulse when `rx_byte` updates.
- `frame_err` output, 1 bit: one-cycle pulse when a stop bit is sampled low.

## Operation
- Input conditioning: `uart_rx` passes through a 2-FF synchronizer; all logic uses the synchronized value `rxs`.
- Receiver FSM states are `WAIT_IDLE`, `IDLE`, `START`, `DATA`, `STOP`.
  - `WAIT_IDLE`: the state entered on reset. Leave to `IDLE` only once `rxs` = 1.
  - `IDLE`: `rxs` = 0 → `START`, with the bit counter cleared.
  - `START`: at count `CLKS_PER_BIT/2`, resample. Low → `DATA`. High → `IDLE` (glitch; no output).
  - `DATA`: sample every `CLKS_PER_BIT` clocks. LSB first. Exactly 8 bits → `STOP`.
  - `STOP`: sample after `CLKS_PER_BIT` clocks.
    - High: `rx_byte` ← data, pulse `rx_valid`, go to `IDLE`.
    - Low: pulse `frame_err`, discard the byte, go to `WAIT_IDLE`.
- Command decode runs on `rx_valid`, on byte `b`:
  - `b[7:4]` = 4'h1: press key `b[3:0]`. Set `keys[b[3:0]]`, `key_idx` ← `b[3:0]`, pulse `key_event`.
  - `b[7:4]` = 4'h2: release key `b[3:0]`. Clear `keys[b[3:0]]`.
  - `b` = 8'h30: release all. `keys` ← 0.
  - Any other byte: ignored. `keys`, `key_idx` and `key_event` are unaffected.
- Press of a key already held: `keys` unchanged, but `key_event` still pulses.
- Release of a key not held: no-op.
- Reset values: `keys` = 0, `key_idx` = 0, `rx_byte` = 0, `key_event` = `rx_valid` = `frame_err` = 0, FSM in `WAIT_IDLE`.
- Reset mid-frame: the partial byte is dropped with no pulses. Because the FSM restarts in `WAIT_IDLE`, it does not mistake a low data bit for a start bit.

## Timing
- Sampling: the start bit is confirmed at half a bit time; the first data bit is sampled `CLKS_PER_BIT` clocks after that; subsequent bits follow at `CLKS_PER_BIT` intervals.
- `rx_valid` and `frame_err` assert in the cycle after the stop-bit sample.
- `keys`, `key_idx` and `key_event` update in the cycle after `rx_valid`, a decode latency of 1 cycle.
- Back-to-back frames with zero idle time between the stop bit and the next start bit are received without loss.
- Pulses never stretch: each output pulse lasts exactly one cycle per byte.

## Configuration
- `KEYPAD_ASCII_EN` defined adds an ASCII hex decode on top of the binary commands:
  - `'0'`–`'9'`, `'a'`–`'f'`, `'A'`–`'F'`: `keys` ← one-hot of that digit, `key_idx` ← digit, pulse `key_event`.
  - `' '` (8'h20): `keys` ← 0.
- Overlap with the binary commands: `'0'` (8'h30) decodes as ASCII digit 0 rather than release-all, and the binary press commands 8'h10–8'h1F remain active.
- `KEYPAD_ASCII_EN` undefined: only the binary commands exist, and all ASCII bytes fall into "ignored".

## Structure
- `chip8_pkg` holds:
  - command nibbles `KP_CMD_PRESS` = 4'h1 and `KP_CMD_RELEASE` = 4'h2;
  - `KP_CMD_CLEAR` = 8'h30;
  - the receiver FSM state enum.
- Sub-module `uart_rx`: synchronizer, FSM and bit counter, producing `rx_byte`, `rx_valid` and `frame_err`.
- `uart_keypad_rx` itself: the command decoder plus the `keys` and `key_idx` registers.

## Test plan
All scenarios use `CLK_FREQ` = 1_000_000 and `BAUD` = 100_000, so `CLKS_PER_BIT` = 10.
- Send 8'h15 → `rx_valid` with `rx_byte` = 8'h15; next cycle `keys` = 16'h0020, `key_idx` = 5, `key_event` high for 1 cycle.
- Send 8'h1A, 8'h13 back-to-back, then 8'h25 → `keys` = 16'h0408; a final 8'h30 → `keys` = 16'h0000.
- Send 8'h12 with the stop bit forced low → `frame_err` pulses; `rx_valid` and `keys` unchanged; the next valid 8'h12 is accepted once the line has been high.
- Low glitch on `uart_rx` lasting 3 clocks → no `rx_valid`, FSM returns to `IDLE`.
- Assert `rst` during data bit 4 of 8'h1F → outputs 0; the remaining frame bits produce no `rx_valid`; a following 8'h11 yields `keys` = 16'h0002.
- With `KEYPAD_ASCII_EN`: send `'B'` (8'h42) → `keys` = 16'h0800, `key_idx` = 11; then send 8'h20 → `keys` = 0.
